pong_mmio_ctrl: RTL and testbench

PONG_MMIO_CTRL -- requirements
Module: pong_mmio_ctrl

---
 rtl/pong_mmio_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_pong_mmio_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_mmio_ctrl.sv
// Pong memory-mapped I/O controller: dmem write gating, shadow registers
// committed on VSYNC, frame counter, and a small PS/2 key FIFO.
module pong_mmio_ctrl #(
  parameter int IO_BASE    = 3000,
  parameter int DMEM_LIMIT = 2000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] addr,
  input  logic [31:0] wdata,
  input  logic        wren,
  input  logic [31:0] dmem_q,
  output logic        dmem_wren,
  output logic [31:0] rdata,
  input  logic        ps2_key_pressed,
  input  logic [7:0]  ps2_key_data,
  input  logic        vga_vs,
  output logic [9:0]  ball_x,
  output logic [8:0]  ball_y,
  output logic [8:0]  paddle_left,
  output logic [8:0]  paddle_right
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [11:0] IO_B  = 12'(IO_BASE);
  localparam logic [11:0] LIM_B = 12'(DMEM_LIMIT);

  // Clamp a full 32-bit store value to a screen coordinate limit.
  function automatic logic [9:0] sat(input logic [31:0] v, input logic [9:0] lim);
    if (v > {22'd0, lim}) begin
      return lim;
    end else begin
      return v[9:0];
    end
  endfunction

  logic        is_dmem;
  logic        is_io;
  logic [11:0] io_off;
  logic        wr_io;
  logic [9:0]  sh_x_r;
  logic [8:0]  sh_y_r, sh_pl_r, sh_pr_r;
  logic        commit_pending_r;
  logic [15:0] frame_cnt_r;
  logic        vs_meta_r, vs_sync_r, vs_prev_r;
  logic        frame_evt;
  logic        key_d1_r, key_d2_r;
  logic [7:0]  key_byte_r;
  logic        push, pop_req, do_push, do_pop, drop;
  logic [7:0]  mem_r [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r;
  logic        overflow_r;
  logic        full, empty;
  logic [7:0]  head;
  logic [31:0] io_val;
  logic        rd_dmem_r;
  logic [31:0] io_rdata_r;

  assign io_off    = addr - IO_B;
  assign is_dmem   = (addr < LIM_B);
  assign is_io     = (addr >= IO_B) && (io_off < 12'd8);
  assign dmem_wren = wren & is_dmem;
  assign wr_io     = wren & is_io;

  assign frame_evt = vs_prev_r & ~vs_sync_r;
  assign push      = key_d1_r & ~key_d2_r;
  assign pop_req   = wr_io && (io_off[2:0] == 3'd6);
  assign full      = (count_r == CW'(FIFO_DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign do_pop    = pop_req & ~empty;
  // A full FIFO still accepts a push when the same edge pops.
  assign do_push   = push & (~full | do_pop);
  assign drop      = push & full & ~do_pop;

  // VSYNC synchronizer plus one delay flop for falling-edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vs_meta_r <= 1'b1;
      vs_sync_r <= 1'b1;
      vs_prev_r <= 1'b1;
    end else begin
      vs_meta_r <= vga_vs;
      vs_sync_r <= vs_meta_r;
      vs_prev_r <= vs_sync_r;
    end
  end

  // Shadow registers, commit flag, frame counter and committed outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sh_x_r           <= 10'd320;
      sh_y_r           <= 9'd240;
      sh_pl_r          <= 9'd240;
      sh_pr_r          <= 9'd240;
      ball_x           <= 10'd320;
      ball_y           <= 9'd240;
      paddle_left      <= 9'd240;
      paddle_right     <= 9'd240;
      commit_pending_r <= 1'b0;
      frame_cnt_r      <= 16'd0;
    end else begin
      if (wr_io && (io_off[2:0] == 3'd0)) sh_x_r  <= sat(wdata, 10'd639);
      if (wr_io && (io_off[2:0] == 3'd1)) sh_y_r  <= 9'(sat(wdata, 10'd479));
      if (wr_io && (io_off[2:0] == 3'd2)) sh_pl_r <= 9'(sat(wdata, 10'd479));
      if (wr_io && (io_off[2:0] == 3'd3)) sh_pr_r <= 9'(sat(wdata, 10'd479));
      if (frame_evt) frame_cnt_r <= frame_cnt_r + 16'd1;
      // Outputs sample the shadows as they stood before this edge's writes.
      if (frame_evt && commit_pending_r) begin
        ball_x       <= sh_x_r;
        ball_y       <= sh_y_r;
        paddle_left  <= sh_pl_r;
        paddle_right <= sh_pr_r;
      end
      // A COMMIT store on the frame edge re-arms rather than being lost.
      if (wr_io && (io_off[2:0] == 3'd4)) begin
        commit_pending_r <= 1'b1;
      end else if (frame_evt) begin
        commit_pending_r <= 1'b0;
      end
    end
  end

  // PS/2 strobe edge detect, capturing the scan code with the strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_d1_r   <= 1'b0;
      key_d2_r   <= 1'b0;
      key_byte_r <= 8'd0;
    end else begin
      key_d1_r   <= ps2_key_pressed;
      key_d2_r   <= key_d1_r;
      key_byte_r <= ps2_key_data;
    end
  end

  // Key FIFO storage, pointers, occupancy and sticky overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 8'd0;
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (do_push) begin
        mem_r[wr_ptr_r] <= key_byte_r;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (do_pop) rd_ptr_r <= rd_ptr_r + PW'(1);
      count_r <= count_r + CW'(do_push) - CW'(do_pop);
      if (drop) begin
        overflow_r <= 1'b1;
      end else if (wr_io && (io_off[2:0] == 3'd5)) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // I/O register read value for the current address.
  always_comb begin
    io_val = 32'd0;
    if (empty) begin
      head = 8'd0;
    end else begin
      head = mem_r[rd_ptr_r];
    end
    case (io_off[2:0])
      3'd0:    io_val = {22'd0, sh_x_r};
      3'd1:    io_val = {23'd0, sh_y_r};
      3'd2:    io_val = {23'd0, sh_pl_r};
      3'd3:    io_val = {23'd0, sh_pr_r};
      3'd4:    io_val = {31'd0, commit_pending_r};
      3'd5:    io_val = {26'd0, overflow_r, 3'(count_r), full, empty};
      3'd6:    io_val = {24'd0, head};
      3'd7:    io_val = {16'd0, frame_cnt_r};
      default: io_val = 32'd0;
    endcase
  end

  // Register the read source so rdata lines up with dmem's one-cycle latency.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_dmem_r  <= 1'b0;
      io_rdata_r <= 32'd0;
    end else begin
      rd_dmem_r  <= is_dmem;
      io_rdata_r <= is_io ? io_val : 32'd0;
    end
  end

  assign rdata = rd_dmem_r ? dmem_q : io_rdata_r;

endmodule

// File: tb/tb_pong_mmio_ctrl.sv
// Self-checking bench for pong_mmio_ctrl: vector table, directed corner
// sequences, and randomized transactions against a queue-based model.
module tb_pong_mmio_ctrl;

  localparam int DEPTH = 4;
  localparam logic [11:0] IO = 12'd3000;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic        wren;
  logic [31:0] dmem_q;
  logic        dmem_wren;
  logic [31:0] rdata;
  logic        ps2_key_pressed;
  logic [7:0]  ps2_key_data;
  logic        vga_vs;
  logic [9:0]  ball_x;
  logic [8:0]  ball_y, paddle_left, paddle_right;

  pong_mmio_ctrl #(.IO_BASE(3000), .DMEM_LIMIT(2000), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .addr(addr), .wdata(wdata), .wren(wren),
    .dmem_q(dmem_q), .dmem_wren(dmem_wren), .rdata(rdata),
    .ps2_key_pressed(ps2_key_pressed), .ps2_key_data(ps2_key_data),
    .vga_vs(vga_vs), .ball_x(ball_x), .ball_y(ball_y),
    .paddle_left(paddle_left), .paddle_right(paddle_right)
  );

  always #5 clock = ~clock;

  // Stand-in dmem: one-cycle read returning a tag plus the address.
  always @(posedge clock) dmem_q <= 32'hA500_0000 | {20'd0, addr};

  int checks = 0;
  int errors = 0;

  // Transaction-level reference model.
  logic [31:0] sh [4];
  logic [31:0] outv [4];
  bit          pend;
  logic [15:0] fcnt;
  logic [7:0]  kq [$];
  bit          ov;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      sh[i]   = (i == 0) ? 32'd320 : 32'd240;
      outv[i] = sh[i];
    end
    pend = 1'b0;
    fcnt = 16'd0;
    kq.delete();
    ov = 1'b0;
  endtask

  function automatic logic [31:0] clamp(input int idx, input logic [31:0] d);
    logic [31:0] lim;
    lim = (idx == 0) ? 32'd639 : 32'd479;
    return (d > lim) ? lim : d;
  endfunction

  function automatic logic [31:0] exp_reg(input int off);
    logic [31:0] r;
    logic [2:0]  c;
    c = 3'(kq.size());
    r = 32'd0;
    if (off < 4) r = sh[off];
    else if (off == 4) r = {31'd0, pend};
    else if (off == 5) r = {26'd0, ov, c, kq.size() == DEPTH, kq.size() == 0};
    else if (off == 6) r = (kq.size() > 0) ? {24'd0, kq[0]} : 32'd0;
    else r = {16'd0, fcnt};
    return r;
  endfunction

  task automatic m_frame();
    fcnt = fcnt + 16'd1;
    if (pend) begin
      for (int i = 0; i < 4; i++) outv[i] = sh[i];
      pend = 1'b0;
    end
  endtask

  task automatic m_push(input logic [7:0] k);
    if (kq.size() == DEPTH) ov = 1'b1;
    else kq.push_back(k);
  endtask

  task automatic m_write(input int off, input logic [31:0] d);
    if (off < 4) sh[off] = clamp(off, d);
    else if (off == 4) pend = 1'b1;
    else if (off == 5) ov = 1'b0;
    else if (off == 6) begin
      if (kq.size() > 0) void'(kq.pop_front());
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_ball_x"}, {22'd0, ball_x}, outv[0]);
    chk({tag, "_ball_y"}, {23'd0, ball_y}, outv[1]);
    chk({tag, "_pad_l"}, {23'd0, paddle_left}, outv[2]);
    chk({tag, "_pad_r"}, {23'd0, paddle_right}, outv[3]);
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d, output logic we);
    @(negedge clock);
    addr = a; wdata = d; wren = 1'b1;
    #1 we = dmem_wren;
    @(negedge clock);
    wren = 1'b0;
  endtask

  task automatic do_read(input logic [11:0] a, output logic [31:0] v);
    @(negedge clock);
    addr = a; wren = 1'b0;
    @(negedge clock);
    v = rdata;
  endtask

  task automatic io_write(input int off, input logic [31:0] d);
    logic we;
    do_write(IO + 12'(off), d, we);
    m_write(off, d);
  endtask

  task automatic io_check(input string name, input int off);
    logic [31:0] v;
    do_read(IO + 12'(off), v);
    chk(name, v, exp_reg(off));
  endtask

  task automatic frame_pulse();
    @(negedge clock);
    vga_vs = 1'b0;
    repeat (3) @(negedge clock);
    vga_vs = 1'b1;
    repeat (3) @(negedge clock);
    m_frame();
  endtask

  // Store landing on the same edge as the frame event.
  task automatic coincide_write(input int off, input logic [31:0] d);
    @(negedge clock);
    vga_vs = 1'b0;
    @(negedge clock);
    @(negedge clock);
    addr = IO + 12'(off); wdata = d; wren = 1'b1;
    @(negedge clock);
    wren = 1'b0; vga_vs = 1'b1;
    repeat (3) @(negedge clock);
    m_frame();
    m_write(off, d);
  endtask

  task automatic key_push(input logic [7:0] k);
    @(negedge clock);
    ps2_key_pressed = 1'b1; ps2_key_data = k;
    @(negedge clock);
    ps2_key_pressed = 1'b0;
    repeat (2) @(negedge clock);
    m_push(k);
  endtask

  // Key push landing on the same edge as a store to off (pop or status clear).
  task automatic key_push_with_write(input logic [7:0] k, input int off);
    @(negedge clock);
    ps2_key_pressed = 1'b1; ps2_key_data = k;
    @(negedge clock);
    ps2_key_pressed = 1'b0;
    addr = IO + 12'(off); wdata = 32'd0; wren = 1'b1;
    @(negedge clock);
    wren = 1'b0;
    repeat (2) @(negedge clock);
    m_write(off, 32'd0);
    m_push(k);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    model_reset();
  endtask

  typedef struct {
    bit          is_wr;
    logic [11:0] a;
    logic [31:0] d;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl [20];

  initial begin
    logic [31:0] v;
    logic        we;
    bit          seen;

    tbl[0]  = '{1'b1, 12'd1500, 32'd5,          32'd1,          "st_1500_wren"};
    tbl[1]  = '{1'b1, 12'd1999, 32'd5,          32'd1,          "st_1999_wren"};
    tbl[2]  = '{1'b1, 12'd2000, 32'd5,          32'd0,          "st_2000_wren"};
    tbl[3]  = '{1'b1, 12'd2500, 32'd77,         32'd0,          "st_2500_wren"};
    tbl[4]  = '{1'b1, 12'd3000, 32'd900,        32'd0,          "st_3000_wren"};
    tbl[5]  = '{1'b0, 12'd3000, 32'd0,          32'd639,        "rd_x_sat"};
    tbl[6]  = '{1'b1, 12'd3000, 32'd638,        32'd0,          "st_x_638"};
    tbl[7]  = '{1'b0, 12'd3000, 32'd0,          32'd638,        "rd_x_638"};
    tbl[8]  = '{1'b1, 12'd3001, 32'd900,        32'd0,          "st_y_900"};
    tbl[9]  = '{1'b0, 12'd3001, 32'd0,          32'd479,        "rd_y_sat"};
    tbl[10] = '{1'b1, 12'd3002, 32'h8000_0001,  32'd0,          "st_pl_big"};
    tbl[11] = '{1'b0, 12'd3002, 32'd0,          32'd479,        "rd_pl_sat32"};
    tbl[12] = '{1'b1, 12'd3003, 32'd479,        32'd0,          "st_pr_479"};
    tbl[13] = '{1'b0, 12'd3003, 32'd0,          32'd479,        "rd_pr_479"};
    tbl[14] = '{1'b0, 12'd2500, 32'd0,          32'd0,          "rd_2500_zero"};
    tbl[15] = '{1'b0, 12'd3008, 32'd0,          32'd0,          "rd_3008_zero"};
    tbl[16] = '{1'b0, 12'd4095, 32'd0,          32'd0,          "rd_4095_zero"};
    tbl[17] = '{1'b0, 12'd1500, 32'd0,          32'hA500_05DC,  "rd_dmem_1500"};
    tbl[18] = '{1'b0, 12'd3004, 32'd0,          32'd0,          "rd_commit_0"};
    tbl[19] = '{1'b0, 12'd3007, 32'd0,          32'd0,          "rd_frame_0"};

    addr = 12'd0; wdata = 32'd0; wren = 1'b0;
    ps2_key_pressed = 1'b0; ps2_key_data = 8'd0; vga_vs = 1'b1;
    apply_reset();

    // Reset state.
    chk("rst_ball_x", {22'd0, ball_x}, 32'd320);
    chk("rst_ball_y", {23'd0, ball_y}, 32'd240);
    chk("rst_pad_l", {23'd0, paddle_left}, 32'd240);
    chk("rst_pad_r", {23'd0, paddle_right}, 32'd240);
    do_read(IO + 12'd5, v);
    chk("rst_keystat", v, 32'h0000_0001);

    // Vector table.
    for (int i = 0; i < 20; i++) begin
      if (tbl[i].is_wr) begin
        do_write(tbl[i].a, tbl[i].d, we);
        chk(tbl[i].name, {31'd0, we}, tbl[i].exp);
      end else begin
        do_read(tbl[i].a, v);
        chk(tbl[i].name, v, tbl[i].exp);
      end
    end
    chk("no_commit_ball_x", {22'd0, ball_x}, 32'd320);
    apply_reset();

    // Commit on VSYNC falling edge; outputs hold until the edge.
    io_write(0, 32'd100);
    io_write(4, 32'd1);
    repeat (4) @(negedge clock);
    chk("pre_edge_ball_x", {22'd0, ball_x}, 32'd320);
    @(negedge clock);
    vga_vs = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4 && !seen; c++) begin
      @(posedge clock);
      #1;
      if (ball_x == 10'd100) seen = 1'b1;
    end
    chk("commit_ball_x", {22'd0, ball_x}, 32'd100);
    @(negedge clock);
    vga_vs = 1'b1;
    repeat (3) @(negedge clock);
    m_frame();
    check_outs("commit");
    io_check("frame_cnt_1", 7);
    io_check("pending_clr", 4);

    // FIFO overflow and pop.
    key_push(8'h1D); key_push(8'h1B); key_push(8'h1C); key_push(8'h23); key_push(8'h2B);
    do_read(IO + 12'd5, v);
    chk("fifo_ovf_stat", v, 32'h0000_0032);
    do_read(IO + 12'd6, v);
    chk("fifo_head_1d", v, 32'h0000_001D);
    io_write(6, 32'd0);
    do_read(IO + 12'd6, v);
    chk("fifo_head_1b", v, 32'h0000_001B);
    key_push(8'h55);
    io_write(5, 32'd0);
    io_check("fifo_full_noovf", 5);

    // Push and pop together while full.
    key_push_with_write(8'h44, 6);
    do_read(IO + 12'd5, v);
    chk("pushpop_full_stat", v, 32'h0000_0012);
    do_read(IO + 12'd6, v);
    chk("pushpop_full_head", v, 32'h0000_001C);

    // Status clear on the same edge as an overflowing push.
    key_push_with_write(8'h77, 5);
    do_read(IO + 12'd5, v);
    chk("ovf_set_wins", v, 32'h0000_0032);

    // Push and pop together while empty.
    for (int i = 0; i < 4; i++) io_write(6, 32'd0);
    io_write(6, 32'd0);
    io_check("pop_empty_noop", 5);
    key_push_with_write(8'h66, 6);
    io_write(5, 32'd0);
    do_read(IO + 12'd5, v);
    chk("pushpop_empty_stat", v, 32'h0000_0004);
    io_check("pushpop_empty_head", 6);

    // Shadow write on the frame edge with a commit pending.
    io_write(2, 32'd100);
    io_write(4, 32'd1);
    coincide_write(2, 32'd200);
    chk("coincide_pad_old", {23'd0, paddle_left}, 32'd100);
    io_check("coincide_shadow_new", 2);
    io_check("coincide_pend_clr", 4);
    io_write(4, 32'd1);
    frame_pulse();
    chk("coincide_pad_new", {23'd0, paddle_left}, 32'd200);

    // COMMIT store on the frame edge keeps the flag set.
    coincide_write(4, 32'd1);
    do_read(IO + 12'd4, v);
    chk("commit_set_wins", v, 32'd1);
    io_check("frame_cnt_dir", 7);

    // Randomized transactions.
    for (int n = 0; n < 250; n++) begin
      int op;
      int off;
      logic [31:0] d;
      op = $urandom_range(0, 9);
      d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 700));
      if (op <= 3) io_write(op, d);
      else if (op == 4) io_write(4, 32'd1);
      else if (op == 5) frame_pulse();
      else if (op == 6) key_push(8'($urandom));
      else if (op == 7) io_write(6, 32'd0);
      else if (op == 8) io_write(5, 32'd0);
      else begin
        off = $urandom_range(0, 7);
        io_check("rand_rd", off);
      end
      if (n % 10 == 0) check_outs("rand");
    end
    for (int i = 0; i < 8; i++) io_check("rand_final_rd", i);
    check_outs("rand_final");

    // Reset mid-operation discards pending commit and FIFO contents.
    io_write(0, 32'd10);
    io_write(4, 32'd1);
    key_push(8'h5A);
    @(negedge clock);
    #2 reset = 1'b1;
    #1 chk("async_rst_ball_x", {22'd0, ball_x}, 32'd320);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    model_reset();
    io_check("midrst_keystat", 5);
    io_check("midrst_pending", 4);
    io_check("midrst_frame", 7);
    frame_pulse();
    check_outs("midrst");
    io_check("midrst_frame_1", 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
